// File: rtl/pipe_merge_if.sv
// Bundles the two upstream beat streams, the global stall, the merged output
// handshake and the sticky overflow flags of pipe_merge.
interface pipe_merge_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data_1;
  logic              in_valid_1;
  logic [DATA_W-1:0] in_data_2;
  logic              in_valid_2;
  logic              stall;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_valid;
  logic              out_ready;
  logic              overflow_1;
  logic              overflow_2;

  modport master (
    output in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
    input  stall, out_data, out_src, out_valid, overflow_1, overflow_2
  );

  modport slave (
    input  in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
    output stall, out_data, out_src, out_valid, overflow_1, overflow_2
  );
endinterface

// File: rtl/pipe_merge.sv
// Merges two upstream pipelines into one stream through per-source FIFOs,
// a round-robin arbiter and a single output register.
module pipe_merge #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  pipe_merge_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR = CW'(DEPTH - 1);

  // Index 0 is pipeline 1, index 1 is pipeline 2 throughout.
  logic [1:0]        in_valid;
  logic [DATA_W-1:0] in_data [2];

  logic [DATA_W-1:0] mem_q   [2][DEPTH];
  logic [CW-1:0]     count_q [2];
  logic [CW-1:0]     count_d [2];
  logic [PW-1:0]     wr_q    [2];
  logic [PW-1:0]     rd_q    [2];
  logic [1:0]        ne, push, pop;
  logic [1:0]        ovf_q, ovf_d;
  logic              rr_q, rr_d;
  logic              loadable, load, grant;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;

  assign in_valid   = {bus.in_valid_2, bus.in_valid_1};
  assign in_data[0] = bus.in_data_1;
  assign in_data[1] = bus.in_data_2;

  // Output handshake: a beat transfers on an edge where out_valid && out_ready;
  // while out_valid is high and out_ready low the register holds and nothing pops.
  always_comb begin
    for (int s = 0; s < 2; s++) ne[s] = (count_q[s] != '0);
    loadable    = !out_valid_q || bus.out_ready;
    load        = loadable && (ne != 2'b00);
    grant       = ne[1] && (!ne[0] || rr_q);
    pop         = 2'b00;
    if (load) pop[grant] = 1'b1;

    // A full FIFO still accepts a beat when its head leaves on the same edge.
    for (int s = 0; s < 2; s++) begin
      push[s]    = in_valid[s] && ((count_q[s] != FULL) || pop[s]);
      ovf_d[s]   = ovf_q[s] | (in_valid[s] & ~push[s]);
      count_d[s] = count_q[s] + CW'(push[s]) - CW'(pop[s]);
    end

    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_d        = rr_q;
    if (load) begin
      out_data_d  = mem_q[grant][rd_q[grant]];
      out_src_d   = grant;
      out_valid_d = 1'b1;
      rr_d        = ~rr_q;
    end else if (loadable) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        count_q[s] <= '0;
        wr_q[s]    <= '0;
        rd_q[s]    <= '0;
      end
      ovf_q       <= 2'b00;
      rr_q        <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        count_q[s] <= count_d[s];
        wr_q[s]    <= wr_q[s] + PW'(push[s]);
        rd_q[s]    <= rd_q[s] + PW'(pop[s]);
      end
      ovf_q       <= ovf_d;
      rr_q        <= rr_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage needs no reset: stale entries sit behind a zero count.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wr_q[s]] <= in_data[s];
    end
  end

  // Raised one slot early so the beat already in flight upstream still fits.
  assign bus.stall      = (count_q[0] >= NEAR) || (count_q[1] >= NEAR);
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.overflow_1 = ovf_q[0];
  assign bus.overflow_2 = ovf_q[1];
endmodule

// File: tb/tb_pipe_merge.sv
// Self-checking bench for pipe_merge: queue-based reference model, scoreboard
// of merged beats, directed scenarios and a randomized run.
module tb_pipe_merge;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_merge_if #(.DATA_W(DW)) intf();
  pipe_merge #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [DW:0]   exp_q[$];
  logic [DW:0]   got_q[$];
  logic [DW-1:0] m_f1[$];
  logic [DW-1:0] m_f2[$];
  logic m_valid = 1'b0, m_rr = 1'b0, m_ov1 = 1'b0, m_ov2 = 1'b0, m_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string name, input logic [DW:0] want[$]);
    check({name, "_len"}, got_q.size(), want.size());
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      check(name, got_q[i], want[i]);
  endtask

  // Reference model: FIFOs as queues, one output slot, rr toggling per load.
  // The head is chosen before this edge's pushes land, so there is no bypass.
  always @(posedge clk) begin
    logic g2;
    logic [DW-1:0] b;
    if (reset) begin
      m_f1.delete(); m_f2.delete(); exp_q.delete();
      m_valid = 1'b0; m_rr = 1'b0; m_ov1 = 1'b0; m_ov2 = 1'b0;
    end else begin
      if (!m_valid || intf.out_ready) begin
        if (m_f1.size() > 0 || m_f2.size() > 0) begin
          g2 = (m_f2.size() > 0) && (m_f1.size() == 0 || m_rr);
          if (g2) b = m_f2.pop_front();
          else    b = m_f1.pop_front();
          exp_q.push_back({g2, b});
          m_valid = 1'b1;
          m_rr    = !m_rr;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (intf.in_valid_1) begin
        if (m_f1.size() < DEPTH) m_f1.push_back(intf.in_data_1);
        else m_ov1 = 1'b1;
      end
      if (intf.in_valid_2) begin
        if (m_f2.size() < DEPTH) m_f2.push_back(intf.in_data_2);
        else m_ov2 = 1'b1;
      end
    end
    m_stall = (m_f1.size() >= DEPTH - 1) || (m_f2.size() >= DEPTH - 1);
  end

  // Monitor: per-cycle status checks and scoreboard pop on each handshake.
  always @(negedge clk) begin
    logic [DW:0] got, e;
    if (mon_en) begin
      check("out_valid", intf.out_valid, m_valid);
      check("stall", intf.stall, m_stall);
      check("overflow_1", intf.overflow_1, m_ov1);
      check("overflow_2", intf.overflow_2, m_ov2);
      if (intf.out_valid && intf.out_ready) begin
        got = {intf.out_src, intf.out_data};
        got_q.push_back(got);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat: got %0h expected none (scoreboard empty)", got);
        end else begin
          e = exp_q.pop_front();
          check("beat", got, e);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    intf.in_valid_1 = 1'b0;
    intf.in_valid_2 = 1'b0;
    intf.in_data_1  = '0;
    intf.in_data_2  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic push1(input logic [DW-1:0] d);
    intf.in_valid_1 = 1'b1;
    intf.in_data_1  = d;
    cycle();
    intf.in_valid_1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle_inputs();
    intf.out_ready = 1'b1;
    while ((exp_q.size() != 0 || m_f1.size() != 0 || m_f2.size() != 0 || intf.out_valid) && n < 64) begin
      cycle();
      n++;
    end
    check("drain_done", {exp_q.size() == 0, intf.out_valid}, 2'b10);
  endtask

  initial begin
    logic [DW:0] want[$];
    idle_inputs();
    intf.out_ready = 1'b1;
    cycle();
    mon_en = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_out_data", intf.out_data, 0);
    check("rst_out_src", intf.out_src, 0);
    check("rst_out_valid", intf.out_valid, 0);

    // Single beat: visible one edge after the push, for exactly one cycle.
    intf.in_valid_1 = 1'b1; intf.in_data_1 = 5;
    cycle();
    intf.in_valid_1 = 1'b0;
    cycle();
    check("single_valid", intf.out_valid, 1);
    check("single_data", intf.out_data, 5);
    check("single_src", intf.out_src, 0);
    cycle();
    check("single_valid_drop", intf.out_valid, 0);

    // Alternation between sources.
    do_reset();
    intf.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      intf.in_valid_1 = 1'b1; intf.in_data_1 = 10 + i;
      intf.in_valid_2 = 1'b1; intf.in_data_2 = 20 + i;
      cycle();
    end
    drain();
    want = '{{1'b0, 32'd10}, {1'b1, 32'd20}, {1'b0, 32'd11}, {1'b1, 32'd21}, {1'b0, 32'd12}, {1'b1, 32'd22}};
    check_seq("alternate", want);

    // Backpressure, then overflow on a sixth beat.
    do_reset();
    intf.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push1(i);
    check("bp_stall", intf.stall, 1);
    check("bp_ovf", intf.overflow_1, 0);
    check("bp_head", intf.out_data, 1);
    push1(6);
    check("ovf_set", intf.overflow_1, 1);
    drain();
    want = '{{1'b0, 32'd1}, {1'b0, 32'd2}, {1'b0, 32'd3}, {1'b0, 32'd4}, {1'b0, 32'd5}};
    check_seq("bp_order", want);
    check("ovf_sticky", intf.overflow_1, 1);

    // Full FIFO replace: pop and push on the same edge.
    do_reset();
    intf.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push1(i);
    intf.out_ready = 1'b1;
    push1(7);
    check("replace_ovf", intf.overflow_1, 0);
    check("replace_stall", intf.stall, 1);
    drain();
    want = '{{1'b0, 32'd1}, {1'b0, 32'd2}, {1'b0, 32'd3}, {1'b0, 32'd4}, {1'b0, 32'd5}, {1'b0, 32'd7}};
    check_seq("replace_order", want);

    // Reset mid-stream with count_1 = 2, count_2 = 3, out_valid = 1.
    do_reset();
    intf.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      intf.in_valid_1 = 1'b1; intf.in_data_1 = 30 + i;
      intf.in_valid_2 = 1'b1; intf.in_data_2 = 40 + i;
      cycle();
    end
    check("mid_pre_valid", intf.out_valid, 1);
    idle_inputs();
    reset = 1'b1;
    cycle();
    check("mid_out_valid", intf.out_valid, 0);
    check("mid_out_data", intf.out_data, 0);
    check("mid_out_src", intf.out_src, 0);
    check("mid_stall", intf.stall, 0);
    check("mid_ovf", {intf.overflow_1, intf.overflow_2}, 0);
    reset = 1'b0;
    got_q.delete();
    intf.out_ready = 1'b1;
    intf.in_valid_2 = 1'b1; intf.in_data_2 = 9;
    cycle();
    intf.in_valid_2 = 1'b0;
    cycle();
    check("post_rst_valid", intf.out_valid, 1);
    check("post_rst_data", intf.out_data, 9);
    check("post_rst_src", intf.out_src, 1);
    drain();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      intf.in_valid_1 = ($urandom_range(0, 99) < 45);
      intf.in_valid_2 = ($urandom_range(0, 99) < 45);
      intf.in_data_1  = $urandom;
      intf.in_data_2  = $urandom;
      intf.out_ready  = ($urandom_range(0, 99) < 70);
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_merge.md
PIPE_MERGE -- requirements
Module: pipe_merge

Interface
REQ-001 Parameter DATA_W, default 32: width of every data bus.
REQ-002 Parameter DEPTH, default 4: entries per input FIFO; power of two, >= 2.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 in_data_1  input  DATA_W: pipeline 1 output data.
REQ-006 in_valid_1  input  1: in_data_1 holds a beat this cycle.
REQ-007 in_data_2  input  DATA_W: pipeline 2 output data.
REQ-008 in_valid_2  input  1: in_data_2 holds a beat this cycle.
REQ-009 stall  output  1: global stall to both upstream pipelines; 1 = hold.
REQ-010 out_data  output  DATA_W: merged data stream.
REQ-011 out_src  output  1: source of out_data; 0 = pipeline 1, 1 = pipeline 2.
REQ-012 out_valid  output  1: out_data/out_src hold a beat.
REQ-013 out_ready  input  1: consumer accepts the beat when out_valid && out_ready.
REQ-014 overflow_1  output  1: sticky; a pipeline-1 beat was dropped.
REQ-015 overflow_2  output  1: sticky; a pipeline-2 beat was dropped.

Function
REQ-016 Each source SHALL own a DEPTH-entry FIFO with a registered occupancy count, range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-017 in_valid_x high at an edge SHALL push in_data_x when count_x < DEPTH, or when count_x == DEPTH and FIFO x is popped at the same edge.
REQ-018 A push refused under REQ-017 SHALL drop the beat and set overflow_x; overflow_x clears only on reset.
REQ-019 Simultaneous push and pop on one FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-020 stall SHALL be 1 whenever count_1 >= DEPTH-1 or count_2 >= DEPTH-1, decoded from registered counts only (no path from in_valid_x or out_ready).
REQ-021 stall SHALL NOT gate pushes; one in-flight beat per source after stall rises is absorbed by the reserved slot.
REQ-022 The output stage SHALL be a single register (out_data, out_src, out_valid), loadable when out_valid == 0 or out_ready == 1.
REQ-023 At a loadable edge, if either FIFO is non-empty, the output register SHALL load the head of the granted FIFO, pop it, and set out_valid = 1; otherwise out_valid SHALL go to 0.
REQ-024 Grant: only one FIFO non-empty -> that FIFO; both non-empty -> FIFO indicated by round-robin pointer rr.
REQ-025 rr SHALL switch to the other source after every load and SHALL hold otherwise.
REQ-026 While out_valid && !out_ready, out_data, out_src, out_valid SHALL remain stable and no FIFO SHALL pop.
REQ-027 Minimum latency: beat pushed at edge k into an empty FIFO with output register loadable at edge k+1 SHALL appear with out_valid = 1 after edge k+1.
REQ-028 Beats from one source SHALL leave in arrival order; no beat SHALL be duplicated.
REQ-029 A push into an empty FIFO and a load at the same edge SHALL not bypass; the pushed beat is loadable no earlier than the next edge.

Reset
REQ-030 With reset high at an edge: counts, FIFO pointers 0; rr selects pipeline 1; out_valid, out_data, out_src, stall, overflow_1, overflow_2 all 0.
REQ-031 Reset SHALL take priority over simultaneous push, pop, and load; FIFO contents are discarded, storage RAM need not clear.
REQ-032 Reset asserted mid-stream SHALL discard all buffered and output-registered beats; first post-reset beat obeys REQ-027.

Verification
REQ-033 Single beat: in_data_1 = 5, in_valid_1 pulsed one cycle, out_ready = 1 -> out_data = 5, out_src = 0, out_valid = 1 for exactly one cycle, one edge after push.
REQ-034 Alternation: both sources valid every cycle (1 = 10,11,12; 2 = 20,21,22), out_ready = 1 -> out_data sequence 10,20,11,21,12,22 with out_src 0,1,0,1,0,1.
REQ-035 Backpressure: out_ready = 0, pipeline 1 pushes 1,2,3,4,5 on consecutive cycles, DEPTH = 4 -> stall = 1 once count_1 reaches 3; 1 in output register, 2..5 in FIFO, overflow_1 = 0; release out_ready -> 1,2,3,4,5 in order.
REQ-036 Overflow: continue REQ-035 with a sixth beat 6 while count_1 = 4 and out_ready = 0 -> beat 6 dropped, overflow_1 = 1 and stays 1 after drain.
REQ-037 Full-FIFO replace: count_1 = 4, out_ready = 1, out_valid = 1, new push 7 -> pop and push same edge, count_1 stays 4, overflow_1 stays 0, 7 emerges last.
REQ-038 Reset mid-stream: assert reset with count_1 = 2, count_2 = 3, out_valid = 1 -> after edge all outputs 0; next beat 9 from pipeline 2 -> out_data = 9, out_src = 1.
